ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event FIFO entries, power of two, 2..16.
REQ-002 Parameter FILTER_LEN, default 4: consecutive equal samples needed to accept a kb_clock level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clock cycles inside a frame before the frame is aborted.
REQ-004 Parameter SUPPRESS_REPEAT, default 1: when 1, a typematic make of an already-held key is not enqueued.
REQ-005 clock  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 kb_clock  input  1  raw PS/2 clock, asynchronous to clock.
REQ-008 kb_data  input  1  raw PS/2 data, asynchronous to clock.
REQ-009 key_valid  output  1  FIFO head holds an event.
REQ-010 key_ready  input  1  consumer accepts head; pop occurs when key_valid and key_ready are both high.
REQ-011 key_dir  output  4  head direction, one-hot: UP 0001, DOWN 0010, LEFT 0100, RIGHT 1000.
REQ-012 key_break  output  1  head event is a release (1) or a press (0).
REQ-013 held  output  4  live one-hot bitmap of currently pressed directions.
REQ-014 frame_error  output  1  one-cycle pulse on start, parity, stop or timeout error.
REQ-015 overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-016 kb_clock and kb_data pass through 2-flop synchronisers; kb_clock is then glitch-filtered per FILTER_LEN; a falling edge of the filtered clock samples synchronised kb_data.
REQ-017 Frame FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled start bit 0, else frame_error and stay IDLE.
REQ-018 DATA captures 8 bits LSB first, 3-bit counter, then PARITY; odd parity over data+parity bit required; STOP requires bit 1.
REQ-019 Parity or stop failure: byte discarded, frame_error pulsed, FSM to IDLE, prefix flags cleared.
REQ-020 Timeout counter resets on every falling edge; reaching TIMEOUT_CYCLES outside IDLE aborts to IDLE with frame_error and cleared prefix flags.
REQ-021 Byte E0 sets ext flag; byte F0 sets brk flag; neither enqueues.
REQ-022 Any other byte forms code {ext, byte}, is looked up, then ext and brk clear.
REQ-023 Mapping: {1,75} or {0,1D} -> UP; {1,72} or {0,1B} -> DOWN; {1,6B} or {0,1C} -> LEFT; {1,74} or {0,23} -> RIGHT; all else ignored without event.
REQ-024 Mapped make sets held bit; mapped break clears it; held updates even when the event is dropped or suppressed.
REQ-025 Mapped event pushes {brk, dir} into FIFO; key_valid high no later than 3 clock cycles after the filtered stop-bit falling edge.
REQ-026 Push when full and no pop in same cycle: event dropped, overflow pulsed, FIFO contents unchanged.
REQ-027 Push and pop in same cycle when full: both succeed, no overflow.
REQ-028 Pop when empty has no effect; key_dir and key_break hold last value when key_valid low.
REQ-029 SUPPRESS_REPEAT=1: make for a direction whose held bit is already 1 updates nothing and enqueues nothing.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-031 reset asserted: FSM IDLE, bit counter and timeout counter 0, ext=brk=0, FIFO empty, held=0000, key_valid=0, key_dir=0000, key_break=0, frame_error=0, overflow=0, synchronisers and filter to 1 (idle bus).
REQ-032 reset mid-frame discards the partial frame; the next start bit after deassertion is decoded normally.

Structure
REQ-033 Package ps2_key_pkg holds scan-code constants (E0, F0, eight mapped codes), one-hot direction constants and the FSM state enum.
REQ-034 Frame reception (REQ-016..020) lives in sub-module ps2_frame_rx, outputting byte, byte_valid pulse and error pulse.

Verification
REQ-035 Send 1D (W), then F0 1D -> events {0,0001} then {1,0001}; held goes 0001 then 0000.
REQ-036 Send E0 74, consumer stalled, then E0 F0 74 -> two queued events {0,1000} then {1,1000}; popped in order.
REQ-037 Corrupt parity on byte 1C -> frame_error pulse, no event, held 0000; next clean 1C -> {0,0100}.
REQ-038 Hold key_ready low; send 5 distinct makes with FIFO_DEPTH=4 -> 4 queued, overflow pulse on 5th, held reflects all 5 keys pressed.
REQ-039 Stop kb_clock after 4 data bits for >50000 cycles -> frame_error, FSM IDLE; following E0 72 -> {0,0010}.
REQ-040 SUPPRESS_REPEAT=1, send 1B three times -> exactly one event {0,0010}; with 0 -> three events.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, direction encodings and frame-receiver state type
// for the PS/2 arrow/WASD key decoder.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BREAK     = 8'hF0;

  localparam logic [7:0] SC_UP_EXT    = 8'h75;
  localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
  localparam logic [7:0] SC_UP_W      = 8'h1D;
  localparam logic [7:0] SC_DOWN_S    = 8'h1B;
  localparam logic [7:0] SC_LEFT_A    = 8'h1C;
  localparam logic [7:0] SC_RIGHT_D   = 8'h23;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Extended codes are the arrow keys, plain codes the WASD cluster.
  function automatic logic [3:0] map_code(input logic ext, input logic [7:0] code);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (ext) begin
      case (code)
        SC_UP_EXT:    dir = DIR_UP;
        SC_DOWN_EXT:  dir = DIR_DOWN;
        SC_LEFT_EXT:  dir = DIR_LEFT;
        SC_RIGHT_EXT: dir = DIR_RIGHT;
        default:      dir = DIR_NONE;
      endcase
    end else begin
      case (code)
        SC_UP_W:      dir = DIR_UP;
        SC_DOWN_S:    dir = DIR_DOWN;
        SC_LEFT_A:    dir = DIR_LEFT;
        SC_RIGHT_D:   dir = DIR_RIGHT;
        default:      dir = DIR_NONE;
      endcase
    end
    return dir;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and deglitches the bus, then assembles
// 11-bit frames into bytes with start/parity/stop/timeout checking.
module ps2_frame_rx
  import ps2_key_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_error
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic           filt_clk;
  logic           filt_prev;
  logic [FCW-1:0] filt_cnt;
  logic           fall;
  logic           bit_in;

  rx_state_t      state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic           parity_ok;
  logic [TCW-1:0] timeout_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], kb_clock};
      data_sync <= {data_sync[0], kb_data};
    end
  end

  // The filtered clock only follows the bus after FILTER_LEN identical samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  assign fall   = filt_prev & ~filt_clk;
  assign bit_in = data_sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_ok   <= 1'b0;
      timeout_cnt <= '0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_error   <= 1'b0;
      if (fall || state == IDLE) begin
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TCW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              rx_error <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {bit_in, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_ok <= ^{shift_reg, bit_in};
            state     <= STOP;
          end
          STOP: begin
            if (bit_in && parity_ok) begin
              rx_byte    <= shift_reg;
              byte_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timeout_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scan codes for arrow and WASD keys into direction
// press/release events, tracking held keys and buffering events in a FIFO.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_dir,
  output logic       key_break,
  output logic [3:0] held,
  output logic       frame_error,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_error;

  logic          ext_flag;
  logic          brk_flag;
  logic [3:0]    byte_dir;
  logic [3:0]    held_next;
  logic          push_req;
  logic [4:0]    push_data;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_next;
  logic          pop;
  logic          full;
  logic          do_push;
  logic [4:0]    head_next;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .kb_clock   (kb_clock),
    .kb_data    (kb_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .rx_error   (rx_error)
  );

  assign frame_error = rx_error;

  // The held bitmap moves on every mapped make/break, whether or not the FIFO takes the event.
  always_comb begin
    byte_dir  = map_code(ext_flag, rx_byte);
    held_next = held;
    push_req  = 1'b0;
    push_data = '0;
    if (byte_valid && rx_byte != SC_EXT && rx_byte != SC_BREAK && byte_dir != DIR_NONE) begin
      if (brk_flag) begin
        held_next = held & ~byte_dir;
        push_req  = 1'b1;
        push_data = {1'b1, byte_dir};
      end else if (SUPPRESS_REPEAT == 0 || (held & byte_dir) == 4'b0000) begin
        held_next = held | byte_dir;
        push_req  = 1'b1;
        push_data = {1'b0, byte_dir};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      held     <= 4'b0000;
    end else begin
      held <= held_next;
      if (rx_error) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == SC_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  assign pop        = key_valid & key_ready;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign do_push    = push_req & (~full | pop);
  assign rd_next    = rd_ptr + PW'(pop);
  assign remain     = count - CW'(pop);
  assign count_next = remain + CW'(do_push);
  // When the FIFO drains to nothing this cycle, a concurrent push becomes the new head directly.
  assign head_next  = (remain == '0) ? push_data : mem[rd_next];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      key_dir   <= 4'b0000;
      key_break <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= push_req & full & ~pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_next;
      count     <= count_next;
      key_valid <= (count_next != '0);
      if (count_next != '0) begin
        {key_break, key_dir} <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench driving two decoders (repeat suppression on/off) from one PS/2 bus
// and checking them against a byte-level event model.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int TMO   = 2000;

  logic clock = 1'b0;
  logic reset;
  logic kb_clock;
  logic kb_data;
  logic [1:0] kr;
  wire  [1:0] kv;
  wire  [1:0] kbrk;
  wire  [1:0] ferr;
  wire  [1:0] ovf;
  wire  [1:0][3:0] kd;
  wire  [1:0][3:0] held_w;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_q [2][16];
  int         exp_n [2];
  logic [3:0] held_m [2];
  logic [3:0] last_dir [2];
  logic       last_brk [2];
  logic       ext_m;
  logic       brk_m;
  int         exp_ferr [2];
  int         exp_ovf [2];
  int         ferr_cnt [2] = '{0, 0};
  int         ovf_cnt [2] = '{0, 0};
  logic       kv_snap [2];

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h5A};

  always #5 clock = ~clock;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
                    .SUPPRESS_REPEAT(1)) dut_sup (
    .clock(clock), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data),
    .key_valid(kv[0]), .key_ready(kr[0]), .key_dir(kd[0]), .key_break(kbrk[0]),
    .held(held_w[0]), .frame_error(ferr[0]), .overflow(ovf[0]));

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
                    .SUPPRESS_REPEAT(0)) dut_rep (
    .clock(clock), .reset(reset), .kb_clock(kb_clock), .kb_data(kb_data),
    .key_valid(kv[1]), .key_ready(kr[1]), .key_dir(kd[1]), .key_break(kbrk[1]),
    .held(held_w[1]), .frame_error(ferr[1]), .overflow(ovf[1]));

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (ferr[i] === 1'b1) ferr_cnt[i]++;
      if (ovf[i] === 1'b1) ovf_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [3:0] ref_dir(input logic ext, input logic [7:0] b);
    logic [3:0] d;
    d = 4'b0000;
    if (ext) begin
      case (b)
        8'h75: d = 4'b0001;
        8'h72: d = 4'b0010;
        8'h6B: d = 4'b0100;
        8'h74: d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end else begin
      case (b)
        8'h1D: d = 4'b0001;
        8'h1B: d = 4'b0010;
        8'h1C: d = 4'b0100;
        8'h23: d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_n[i] = 0;
      held_m[i] = 4'b0000;
      last_dir[i] = 4'b0000;
      last_brk[i] = 1'b0;
    end
    ext_m = 1'b0;
    brk_m = 1'b0;
  endtask

  task automatic model_push(input int i, input logic [4:0] e);
    if (exp_n[i] == DEPTH) begin
      exp_ovf[i]++;
    end else begin
      exp_q[i][exp_n[i]] = e;
      exp_n[i]++;
    end
  endtask

  // Instance 0 drops a make for a direction that is already held; instance 1 does not.
  task automatic model_byte(input logic [7:0] b);
    logic [3:0] d;
    if (b == 8'hE0) begin
      ext_m = 1'b1;
    end else if (b == 8'hF0) begin
      brk_m = 1'b1;
    end else begin
      d = ref_dir(ext_m, b);
      if (d != 4'b0000) begin
        for (int i = 0; i < 2; i++) begin
          if (brk_m) begin
            held_m[i] = held_m[i] & ~d;
            model_push(i, {1'b1, d});
          end else if (!(i == 0 && (held_m[i] & d) != 4'b0000)) begin
            held_m[i] = held_m[i] | d;
            model_push(i, {1'b0, d});
          end
        end
      end
      ext_m = 1'b0;
      brk_m = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits,
                            input bit glitch);
    logic [10:0] bits;
    logic p;
    int h;
    p = ~(^b);
    if (bad_parity) p = ~p;
    bits = {1'b1, p, b, 1'b0};
    h = $urandom_range(10, 14);
    for (int k = 0; k < nbits; k++) begin
      kb_data = bits[k];
      if (glitch && k == 5) begin
        cycles(h / 2);
        kb_clock = 1'b0;
        cycles(1);
        kb_clock = 1'b1;
        cycles(h - h / 2 - 1);
      end else begin
        cycles(h);
      end
      kb_clock = 1'b0;
      if (k == 10) begin
        cycles(9);
        kv_snap[0] = kv[0];
        kv_snap[1] = kv[1];
        cycles(h - 9);
      end else begin
        cycles(h);
      end
      kb_clock = 1'b1;
    end
    cycles(h);
    kb_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_parity);
    send_frame(b, bad_parity, 11, ($urandom_range(0, 3) == 0));
    if (bad_parity) begin
      exp_ferr[0]++;
      exp_ferr[1]++;
      ext_m = 1'b0;
      brk_m = 1'b0;
    end else begin
      model_byte(b);
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("latency_valid%0d", i), kv_snap[i], (exp_n[i] != 0));
  endtask

  task automatic drain(input int i);
    check($sformatf("valid%0d", i), kv[i], (exp_n[i] != 0));
    while (exp_n[i] > 0) begin
      check($sformatf("head_dir%0d", i), kd[i], exp_q[i][0][3:0]);
      check($sformatf("head_break%0d", i), kbrk[i], exp_q[i][0][4]);
      last_dir[i] = exp_q[i][0][3:0];
      last_brk[i] = exp_q[i][0][4];
      for (int k = 0; k < exp_n[i] - 1; k++) exp_q[i][k] = exp_q[i][k + 1];
      exp_n[i]--;
      kr[i] = 1'b1;
      cycles(1);
      kr[i] = 1'b0;
    end
    check($sformatf("empty%0d", i), kv[i], 1'b0);
    kr[i] = 1'b1;
    cycles(1);
    kr[i] = 1'b0;
    check($sformatf("empty_pop%0d", i), kv[i], 1'b0);
    check($sformatf("hold_dir%0d", i), kd[i], last_dir[i]);
    check($sformatf("hold_break%0d", i), kbrk[i], last_brk[i]);
  endtask

  task automatic status();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("held%0d", i), held_w[i], held_m[i]);
      check($sformatf("frame_errors%0d", i), ferr_cnt[i], exp_ferr[i]);
      check($sformatf("overflows%0d", i), ovf_cnt[i], exp_ovf[i]);
    end
  endtask

  task automatic drain_all();
    drain(0);
    drain(1);
    status();
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_valid%0d", i), kv[i], 1'b0);
      check($sformatf("rst_dir%0d", i), kd[i], 4'b0000);
      check($sformatf("rst_break%0d", i), kbrk[i], 1'b0);
      check($sformatf("rst_held%0d", i), held_w[i], 4'b0000);
      check($sformatf("rst_ferr%0d", i), ferr[i], 1'b0);
      check($sformatf("rst_ovf%0d", i), ovf[i], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    kb_clock = 1'b1;
    kb_data = 1'b1;
    kr = 2'b00;
    exp_ferr = '{0, 0};
    exp_ovf = '{0, 0};
    model_reset();
    cycles(5);
    check_reset_outputs();
    reset = 1'b0;
    cycles(5);

    // W press then release
    send_byte(8'h1D, 0);
    drain_all();
    send_byte(8'hF0, 0);
    send_byte(8'h1D, 0);
    drain_all();

    // right arrow press and release queued with consumer stalled
    send_byte(8'hE0, 0);
    send_byte(8'h74, 0);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h74, 0);
    status();
    drain_all();

    // corrupted parity, then clean A press and release
    send_byte(8'h1C, 1);
    drain_all();
    send_byte(8'h1C, 0);
    drain_all();
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    drain_all();

    // five makes into a four-deep FIFO
    send_byte(8'h1D, 0);
    send_byte(8'h1B, 0);
    send_byte(8'h1C, 0);
    send_byte(8'h23, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    status();
    drain_all();
    foreach (pool[k]) begin
      if (k >= 2 && k <= 5) begin
        send_byte(8'hF0, 0);
        send_byte(pool[k], 0);
      end
    end
    drain_all();

    // frame stalls after four data bits
    send_frame(8'h72, 0, 5, 0);
    cycles(TMO + 100);
    exp_ferr[0]++;
    exp_ferr[1]++;
    ext_m = 1'b0;
    brk_m = 1'b0;
    status();
    send_byte(8'hE0, 0);
    send_byte(8'h72, 0);
    drain_all();
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h72, 0);
    drain_all();

    // typematic repeat of S
    repeat (3) send_byte(8'h1B, 0);
    drain_all();
    send_byte(8'hF0, 0);
    send_byte(8'h1B, 0);
    drain_all();

    // reset in the middle of a frame while a key is held
    send_byte(8'h1D, 0);
    drain_all();
    send_frame(8'h23, 0, 4, 0);
    reset = 1'b1;
    cycles(3);
    check_reset_outputs();
    model_reset();
    reset = 1'b0;
    cycles(3);
    send_byte(8'h23, 0);
    drain_all();
    send_byte(8'hF0, 0);
    send_byte(8'h23, 0);
    drain_all();

    // randomized byte stream with occasional corruption and stalled consumer
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 11)];
      send_byte(b, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 1) == 1) drain_all();
    end
    drain_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
